hazard_stall_ctrl: RTL and testbench

Stall/bubble controller for the five-stage pipeline. It decides each cycle whether the PC and the IF/ID register hold and whether a bubble is injected into ID/EX. Two stall sources are combined: a Tuse/Tnew register-dependency check and a multi-cycle multiply/divide busy sequencer. The block sits beside the IF/ID and ID/EX registers and drives their hold and clear inputs.

---
 rtl/hazard_stall_ctrl_pkg.sv | 17 +
 rtl/hazard_stall_ctrl_if.sv | 33 +++
 rtl/hazard_stall_ctrl_md_busy_seq.sv | 53 +++++
 rtl/hazard_stall_ctrl.sv | 60 ++++++
 tb/tb_hazard_stall_ctrl.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline definitions for the stall controller: Tuse/Tnew encodings,
// mult/div sequencer states and default unit latencies.
package hazard_stall_ctrl_pkg;

    // Tuse/Tnew are "cycles until needed/available"; 3 as a Tuse means not read
    typedef logic [1:0] stage_dist_t;
    localparam stage_dist_t TUSE_NONE = 2'd3;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Decode/execute/memory hazard fields in, hold/bubble and mult/div status out.
interface hazard_stall_ctrl_if;
    import hazard_stall_ctrl_pkg::*;

    logic [4:0]  D_rs;
    logic [4:0]  D_rt;
    stage_dist_t D_rs_tuse;
    stage_dist_t D_rt_tuse;
    logic        D_is_md;
    logic [4:0]  E_wa;
    stage_dist_t E_tnew;
    logic [4:0]  M_wa;
    stage_dist_t M_tnew;
    logic        E_md_start;
    logic        E_md_div;
    logic        stall;
    logic        DE_clr;
    logic        md_busy;
    logic        md_done;

    modport master (
        output D_rs, D_rt, D_rs_tuse, D_rt_tuse, D_is_md,
        output E_wa, E_tnew, M_wa, M_tnew, E_md_start, E_md_div,
        input  stall, DE_clr, md_busy, md_done
    );

    modport slave (
        input  D_rs, D_rt, D_rs_tuse, D_rt_tuse, D_is_md,
        input  E_wa, E_tnew, M_wa, M_tnew, E_md_start, E_md_div,
        output stall, DE_clr, md_busy, md_done
    );

endinterface

// File: rtl/hazard_stall_ctrl_md_busy_seq.sv
// Mult/div occupancy sequencer: counts the unit's busy cycles after a start
// and pulses md_done on the cycle after busy ends.
module md_busy_seq
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic start_div,
    output logic md_busy,
    output logic md_done
);

    md_state_t  state;
    logic [3:0] cnt;

    // A start seen while busy is dropped: D stalls on md_busy, so a second
    // mult/div cannot legally reach E before the unit frees up.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= MD_IDLE;
            cnt     <= 4'd0;
            md_done <= 1'b0;
        end else begin
            md_done <= 1'b0;
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        cnt   <= start_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                        state <= MD_BUSY;
                    end
                end
                MD_BUSY: begin
                    if (cnt == 4'd1) begin
                        cnt     <= 4'd0;
                        state   <= MD_IDLE;
                        md_done <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

    // Taken straight from the state flop so an async reset clears it at once
    assign md_busy = (state == MD_BUSY);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/bubble controller: Tuse/Tnew dependency check plus the
// mult/div busy sequencer, driving the IF/ID hold and ID/EX clear.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset,
    hazard_stall_ctrl_if.slave   bus
);

    logic rs_hazard;
    logic rt_hazard;
    logic md_stall;
    logic md_busy_int;

    // A source stalls when a producer in E or M still needs more cycles than
    // D can wait; $zero and unread operands never stall.
    function automatic logic src_hazard(
        input logic [4:0]  ra,
        input stage_dist_t tuse,
        input logic [4:0]  e_wa,
        input stage_dist_t e_tnew,
        input logic [4:0]  m_wa,
        input stage_dist_t m_tnew
    );
        logic e_hit;
        logic m_hit;
        e_hit = (e_wa == ra) && (e_tnew > tuse);
        m_hit = (m_wa == ra) && (m_tnew > tuse);
        return (ra != 5'd0) && (tuse != TUSE_NONE) && (e_hit || m_hit);
    endfunction

    md_busy_seq #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_seq (
        .clk       (clk),
        .reset     (reset),
        .start     (bus.E_md_start),
        .start_div (bus.E_md_div),
        .md_busy   (md_busy_int),
        .md_done   (bus.md_done)
    );

    always_comb begin
        rs_hazard = src_hazard(bus.D_rs, bus.D_rs_tuse, bus.E_wa, bus.E_tnew,
                               bus.M_wa, bus.M_tnew);
        rt_hazard = src_hazard(bus.D_rt, bus.D_rt_tuse, bus.E_wa, bus.E_tnew,
                               bus.M_wa, bus.M_tnew);
        md_stall  = bus.D_is_md && (md_busy_int || bus.E_md_start);
    end

    assign bus.md_busy = md_busy_int;
    assign bus.stall   = rs_hazard || rt_hazard || md_stall;
    assign bus.DE_clr  = bus.stall;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a cycle-index reference model.
module tb_hazard_stall_ctrl;
    import hazard_stall_ctrl_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk = 1'b0;
    logic reset;

    hazard_stall_ctrl_if bus ();

    hazard_stall_ctrl #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: a unit run is remembered as (start cycle, length); busy and done
    // follow from where the current cycle index falls relative to it.
    int cyc       = 0;
    bit have_run  = 1'b0;
    int run_start = 0;
    int run_len   = 0;

    function automatic bit run_busy_at(int c);
        return have_run && (c >= run_start + 1) && (c <= run_start + run_len);
    endfunction

    function automatic bit dep_hazard(logic [4:0] ra, logic [1:0] tuse);
        int tu;
        tu = int'(tuse);
        if (ra == 5'd0 || tu == 3) return 1'b0;
        return ((bus.E_wa == ra) && (int'(bus.E_tnew) > tu)) ||
               ((bus.M_wa == ra) && (int'(bus.M_tnew) > tu));
    endfunction

    task automatic check_output(string name, logic act, logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (reset !== 1'b1) begin
            have_run = 1'b0;
        end else if (bus.E_md_start === 1'b1 && !run_busy_at(cyc)) begin
            have_run  = 1'b1;
            run_start = cyc;
            run_len   = (bus.E_md_div === 1'b1) ? DIV_N : MULT_N;
        end
        cyc++;
    end

    always @(negedge clk) begin
        bit exp_busy;
        bit exp_done;
        bit exp_stall;
        exp_busy  = (reset === 1'b1) && run_busy_at(cyc);
        exp_done  = (reset === 1'b1) && have_run && (cyc == run_start + run_len + 1);
        exp_stall = dep_hazard(bus.D_rs, bus.D_rs_tuse) ||
                    dep_hazard(bus.D_rt, bus.D_rt_tuse) ||
                    (bus.D_is_md && (exp_busy || bus.E_md_start));
        check_output("model_stall",   bus.stall,   exp_stall);
        check_output("model_DE_clr",  bus.DE_clr,  exp_stall);
        check_output("model_md_busy", bus.md_busy, exp_busy);
        check_output("model_md_done", bus.md_done, exp_done);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.D_rs       = 5'd0;
        bus.D_rt       = 5'd0;
        bus.D_rs_tuse  = TUSE_NONE;
        bus.D_rt_tuse  = TUSE_NONE;
        bus.D_is_md    = 1'b0;
        bus.E_wa       = 5'd0;
        bus.E_tnew     = 2'd0;
        bus.M_wa       = 5'd0;
        bus.M_tnew     = 2'd0;
        bus.E_md_start = 1'b0;
        bus.E_md_div   = 1'b0;
    endtask

    task automatic apply_stimulus();
        reset          = ($urandom_range(0, 99) != 0);
        bus.D_rs       = 5'($urandom_range(0, 3));
        bus.D_rt       = 5'($urandom_range(0, 3));
        bus.D_rs_tuse  = 2'($urandom_range(0, 3));
        bus.D_rt_tuse  = 2'($urandom_range(0, 3));
        bus.D_is_md    = ($urandom_range(0, 2) == 0);
        bus.E_wa       = 5'($urandom_range(0, 3));
        bus.E_tnew     = 2'($urandom_range(0, 3));
        bus.M_wa       = 5'($urandom_range(0, 3));
        bus.M_tnew     = 2'($urandom_range(0, 3));
        bus.E_md_start = ($urandom_range(0, 7) == 0);
        bus.E_md_div   = 1'($urandom_range(0, 1));
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        bus.E_md_start = 1'b1;
        #3;
        check_output("rst_busy", bus.md_busy, 1'b0);
        check_output("rst_done", bus.md_done, 1'b0);
        step();
        #2;
        check_output("rst_busy_hold", bus.md_busy, 1'b0);
        step();
        reset = 1'b1;
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            step();
            #2;
            check_output("post_rst_idle", bus.md_busy, 1'b0);
        end

        step();
        clear_inputs();
        bus.E_wa = 5'd5; bus.E_tnew = 2'd2; bus.D_rs = 5'd5; bus.D_rs_tuse = 2'd1;
        #2;
        check_output("load_use_stall", bus.stall, 1'b1);
        check_output("load_use_clr", bus.DE_clr, 1'b1);
        step();
        bus.E_tnew = 2'd1;
        #2;
        check_output("load_use_ready", bus.stall, 1'b0);

        step();
        clear_inputs();
        bus.E_wa = 5'd0; bus.D_rs = 5'd0; bus.D_rs_tuse = 2'd0; bus.E_tnew = 2'd2;
        #2;
        check_output("reg0_no_stall", bus.stall, 1'b0);

        step();
        clear_inputs();
        bus.D_rt = 5'd7; bus.D_rt_tuse = TUSE_NONE; bus.M_wa = 5'd7; bus.M_tnew = 2'd1;
        #2;
        check_output("rt_unread", bus.stall, 1'b0);
        step();
        bus.D_rt_tuse = 2'd0;
        #2;
        check_output("rt_m_hazard", bus.stall, 1'b1);

        step();
        clear_inputs();
        bus.D_rs = 5'd9; bus.D_rt = 5'd9; bus.D_rs_tuse = 2'd0; bus.D_rt_tuse = 2'd0;
        bus.E_wa = 5'd9; bus.E_tnew = 2'd1;
        #2;
        check_output("rs_eq_rt_stall", bus.stall, 1'b1);

        step();
        clear_inputs();
        bus.D_is_md = 1'b1; bus.E_md_start = 1'b1; bus.E_md_div = 1'b0;
        #2;
        check_output("mult_c0_stall", bus.stall, 1'b1);
        check_output("mult_c0_busy", bus.md_busy, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            step();
            clear_inputs();
            bus.D_is_md = 1'b1;
            #2;
            check_output("mult_busy", bus.md_busy, 1'(i <= 5));
            check_output("mult_done", bus.md_done, 1'(i == 6));
            check_output("mult_stall", bus.stall, 1'(i <= 5));
        end

        step();
        clear_inputs();
        bus.E_md_start = 1'b1; bus.E_md_div = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            clear_inputs();
            if (i == 3) bus.E_md_start = 1'b1;
            #2;
            check_output("div_busy", bus.md_busy, 1'(i <= 10));
            check_output("div_done", bus.md_done, 1'(i == 11));
        end

        step();
        clear_inputs();
        bus.E_md_start = 1'b1; bus.E_md_div = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            clear_inputs();
        end
        step();
        reset = 1'b0;
        #2;
        check_output("async_rst_busy", bus.md_busy, 1'b0);
        step();
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            #2;
            check_output("async_rst_no_done", bus.md_done, 1'b0);
            check_output("async_rst_idle", bus.md_busy, 1'b0);
        end

        for (int i = 0; i < 3000; i++) begin
            step();
            apply_stimulus();
        end
        step();
        reset = 1'b1;
        clear_inputs();
        step();

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
